csa_resolve: RTL and testbench

Carry-propagate stage that sits directly downstream of the 13-bit carry-save adder. It accepts one redundant (sum, carry) pair per transaction over a valid/ready handshake and resolves it into an exact binary result. The add runs serially, CHUNK bits per cycle, so the ripple path is bounded to one chunk. The result is presented to the next stage with its own valid/ready handshake.

---
 rtl/csa_resolve.sv | 110 +++++++++++
 tb/tb_csa_resolve.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/csa_resolve.sv
// Resolves a redundant (sum, carry) pair from the upstream carry-save adder into
// an exact binary result, CHUNK bits per cycle, behind valid/ready handshakes.
module csa_resolve #(
  parameter int WIDTH = 13,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] result
);

  localparam int RW     = WIDTH + 2;
  localparam int NCHUNK = (RW + CHUNK - 1) / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [RW-1:0]   r_a;
  logic [RW-1:0]   r_b;
  logic [RW-1:0]   r_result;
  logic [KW-1:0]   r_k;
  logic            r_c;
  logic            r_out_valid;

  logic            w_accept;
  logic            w_last;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_chunk_sum;

  // in_ready depends only on state and out_ready so no comb path from in_valid.
  assign in_ready  = !rst && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_k == K_LAST);
  assign out_valid = r_out_valid;
  assign result    = r_result;

  // NOTE: every variable an always_comb block writes gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int j = 0; j < CHUNK; j++) begin
      if (int'(r_k) * CHUNK + j < RW) begin
        w_a_chunk[j] = r_a[int'(r_k) * CHUNK + j];
        w_b_chunk[j] = r_b[int'(r_k) * CHUNK + j];
      end
    end
    w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_c};
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next_state = S_BUSY;
      S_BUSY: if (w_last) w_next_state = S_DONE;
      S_DONE: if (out_ready) w_next_state = in_valid ? S_BUSY : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: all datapath registers are plain flops, not memories, so resetting
  // them is cheap and gives the defined zero result after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_k         <= '0;
      r_c         <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a <= RW'(sum_in);
        r_b <= {1'b0, carry_in, 1'b0};
        r_k <= '0;
        r_c <= 1'b0;
      end else if (r_state == S_BUSY) begin
        for (int i = 0; i < RW; i++) begin
          if (i / CHUNK == int'(r_k)) r_result[i] <= w_chunk_sum[i % CHUNK];
        end
        // The final chunk's carry-out cannot be set since the sum fits in RW bits.
        r_c <= w_last ? 1'b0 : w_chunk_sum[CHUNK];
        r_k <= w_last ? '0 : r_k + 1'b1;
      end
      r_out_valid <= (w_next_state == S_DONE);
    end
  end

endmodule

// File: tb/tb_csa_resolve.sv
// Self-checking bench for csa_resolve: directed corner cases plus a random
// end-to-end run through a behavioural carry-save adder with a queue model.
module tb_csa_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] sum_in;
  logic [12:0] carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] result;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  bit stop_rand = 1'b0;

  always #5 clk = ~clk;

  csa_resolve #(.WIDTH(13), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One transaction with out_ready held high; checks accept, latency and value.
  task automatic run_one(input string tag, input logic [12:0] s, input logic [12:0] c,
                         input logic [14:0] exp);
    int cyc;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sum_in    = s;
    carry_in  = c;
    #1;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    sum_in   = 13'($urandom);
    carry_in = 13'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd4);
    check({tag, "_result"}, 32'(result), 32'(exp));
  endtask

  initial begin
    int cyc;
    logic [31:0] bp_exp;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum_in    = '0;
    carry_in  = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_in_ready_held", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready_release", 32'(in_ready), 32'd1);

    run_one("basic", 13'h0005, 13'h0003, 15'h000B);
    run_one("max", 13'h1FFF, 13'h1FFF, 15'h5FFD);
    run_one("ripple", 13'h1FFF, 13'h0001, 15'h2001);

    // Back-pressure: hold the result for 10 cycles, then same-edge handoff.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sum_in    = 13'h1234;
    carry_in  = 13'h0ABC;
    bp_exp    = 32'h1234 + 32'h0ABC * 2;
    #1;
    check("bp_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom);
      sum_in   = 13'($urandom);
      carry_in = 13'($urandom);
      #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_result", 32'(result), bp_exp);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b1;
    sum_in    = 13'h0001;
    carry_in  = 13'h0000;
    out_ready = 1'b1;
    #1;
    check("handoff_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("handoff_drop", 32'(out_valid), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("handoff_latency", 32'(cyc), 32'd4);
    check("handoff_result", 32'(result), 32'h0001);

    // Reset asserted during the second BUSY cycle.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sum_in    = 13'h1FFF;
    carry_in  = 13'h1FFF;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_in_ready_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_in_ready_release", 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_output", 32'(out_valid), 32'd0);
    end
    run_one("after_abort", 13'h0005, 13'h0003, 15'h000B);

    // Random end-to-end through a behavioural carry-save adder.
    @(negedge clk);
    in_valid = 1'b0;
    fork
      begin : driver
        logic [12:0] a, b, c;
        for (int i = 0; i < 1000 && !stop_rand; i++) begin
          a = 13'($urandom);
          b = 13'($urandom);
          c = 13'($urandom);
          repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            in_valid = 1'b0;
          end
          @(negedge clk);
          in_valid = 1'b1;
          sum_in   = a ^ b ^ c;
          carry_in = (a & b) | (a & c) | (b & c);
          #1;
          while (!in_ready && !stop_rand) begin
            @(negedge clk);
            #1;
          end
          exp_q.push_back(int'(a) + int'(b) + int'(c));
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin : monitor
        int got = 0;
        int mcyc = 0;
        while (got < 1000 && mcyc < 40000) begin
          @(negedge clk);
          mcyc++;
          out_ready = ($urandom_range(0, 3) != 0);
          #1;
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("rand_extra_output", 32'd1, 32'd0);
            else check("rand_result", 32'(result), 32'(exp_q.pop_front()));
            got++;
          end
        end
        check("rand_count", 32'(got), 32'd1000);
        stop_rand = 1'b1;
      end
    join
    check("rand_leftover", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
